multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 16: maximum consecutive cycles waiting for mem_ready before a fault is raised.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port inst_opc, input, 7: opcode field from the instruction register, valid from DECODE onward.
REQ-005 SHALL have port take_branch, input, 1: branch comparator result, valid in EXEC.
REQ-006 SHALL have port mem_ready, input, 1: memory completes the current read or write in this cycle.
REQ-007 SHALL have port CTL_IrWrite, output, 1: instruction register load strobe.
REQ-008 SHALL have port CTL_PcWrite, output, 1: PC update strobe.
REQ-009 SHALL have port CTL_PcSel, output, 2: next-PC select: 0 = PC+4, 1 = PC+imm, 2 = rs1+imm.
REQ-010 SHALL have port CTL_RegWrite, output, 1: register file write enable.
REQ-011 SHALL have port CTL_AluOp, output, aluop_t: ALU operation class.
REQ-012 SHALL have port CTL_AluSrc, output, 1: 1 selects immediate as ALU operand B.
REQ-013 SHALL have port CTL_MemRead, output, 1: memory read request.
REQ-014 SHALL have port CTL_MemWrite, output, 1: memory write request.
REQ-015 SHALL have port CTL_MemToReg, output, 3: writeback select: 0 = ALU, 1 = memory, 2 = PC+4, 3 = immediate.
REQ-016 SHALL have port CTL_Fault, output, 1: sticky fault flag.
REQ-017 SHALL have port instr_retired, output, 1: one-cycle pulse per completed instruction.

Function
REQ-018 SHALL implement the states FETCH, DECODE, EXEC, MEM, WB and FAULT.
REQ-019 FETCH SHALL assert CTL_MemRead; on mem_ready it SHALL pulse CTL_IrWrite in the same cycle and go to DECODE, otherwise it SHALL stay in FETCH.
REQ-020 DECODE SHALL last one cycle and SHALL latch inst_opc into an internal opcode register; all later states SHALL use the latched opcode.
REQ-021 DECODE SHALL go to FAULT on an opcode outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111}, and to EXEC otherwise.
REQ-022 EXEC for a branch (1100011) SHALL assert CTL_PcWrite, select PcSel 1 if take_branch else 0, pulse instr_retired, and go to FETCH.
REQ-023 EXEC for a load or store SHALL drive CTL_AluOp ADD with CTL_AluSrc 1 and go to MEM.
REQ-024 EXEC for all other opcodes SHALL go to WB.
REQ-025 CTL_AluSrc SHALL be 1 for the I-ALU, load, store, JALR and AUIPC opcodes, and 0 otherwise.
REQ-026 MEM for a load SHALL assert CTL_MemRead until mem_ready, then go to WB.
REQ-027 MEM for a store SHALL assert CTL_MemWrite until mem_ready; on mem_ready it SHALL assert CTL_PcWrite with PcSel 0, pulse instr_retired and go to FETCH.
REQ-028 WB SHALL assert CTL_RegWrite and CTL_PcWrite for one cycle, pulse instr_retired, and go to FETCH.
REQ-029 In WB, PcSel SHALL be 1 for JAL, 2 for JALR and 0 otherwise.
REQ-030 In WB, MemToReg SHALL be 1 for a load, 2 for JAL and JALR, 3 for LUI and 0 otherwise.
REQ-031 CTL_MemRead and CTL_MemWrite SHALL never be asserted together.
REQ-032 Every enable not named for the current state SHALL be 0.
REQ-033 With zero-wait memory, latency SHALL be 3 cycles for a branch, 4 cycles for a store or any WB-class instruction, and 5 cycles for a load.
REQ-034 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_ready is low.
REQ-035 When the wait counter reaches STALL_LIMIT, the block SHALL go to FAULT; a mem_ready arriving in that same cycle SHALL take priority over the fault.
REQ-036 FAULT SHALL hold CTL_Fault = 1 with all enables 0 until reset.

Reset
REQ-037 While rst is high, the state SHALL be FETCH, all enables and instr_retired SHALL be 0, CTL_PcSel 0, CTL_MemToReg 0, CTL_Fault 0, and the wait counter 0.
REQ-038 Asserting rst mid-instruction SHALL abort it immediately, with no write strobe issued.

Verification
REQ-039 R-type 0110011 with mem_ready held high -> CTL_IrWrite in cycle 1, CTL_RegWrite + CTL_PcWrite (PcSel 0, MemToReg 0) in cycle 4, instr_retired in cycle 4.
REQ-040 Load with read memory delayed 3 cycles -> CTL_MemRead held 4 cycles in MEM, then WB with MemToReg 1.
REQ-041 Branch with take_branch = 1, then 0 -> PcSel 1, then 0, each in cycle 3 with CTL_PcWrite, and CTL_RegWrite never asserted.
REQ-042 Opcode 1111111 -> FAULT after DECODE, CTL_Fault = 1 held, and all enables 0 for 20 cycles.
REQ-043 mem_ready held low in FETCH with STALL_LIMIT = 16 -> CTL_Fault asserted after 16 cycles; the same case with mem_ready high on cycle 16 -> no fault.
REQ-044 rst pulsed during a store wait -> CTL_MemWrite drops asynchronously, and the block restarts in FETCH.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Drives datapath strobes, bounds memory waits with a stall counter and
// parks in a sticky FAULT state on illegal opcodes or memory timeouts.
//
// CTL_AluOp encoding: 0 = ADD (address / link / upper-immediate math),
//                     1 = branch compare, 2 = R-type funct, 3 = I-type funct.
module multicycle_control #(
  parameter int STALL_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] inst_opc,
  input  logic       take_branch,
  input  logic       mem_ready,
  output logic       CTL_IrWrite,
  output logic       CTL_PcWrite,
  output logic [1:0] CTL_PcSel,
  output logic       CTL_RegWrite,
  output logic [1:0] CTL_AluOp,
  output logic       CTL_AluSrc,
  output logic       CTL_MemRead,
  output logic       CTL_MemWrite,
  output logic [2:0] CTL_MemToReg,
  output logic       CTL_Fault,
  output logic       instr_retired
);

  localparam int CNT_W = $clog2(STALL_LIMIT + 1);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [2:0]       state_q, state_d;
  logic [6:0]       opc_q, opc_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic       opc_in_valid;
  logic       is_load, is_store, is_br, is_jal, is_jalr, is_lui;
  logic [1:0] alu_op_dec;
  logic       alu_src_dec;
  logic       stall_hit;

  // Opcode legality (on the live input, used in DECODE) and latched-opcode classes.
  always_comb begin
    opc_in_valid = 1'b0;
    case (inst_opc)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opc_in_valid = 1'b1;
      default:                           opc_in_valid = 1'b0;
    endcase
    is_load  = (opc_q == OP_LOAD);
    is_store = (opc_q == OP_STORE);
    is_br    = (opc_q == OP_BR);
    is_jal   = (opc_q == OP_JAL);
    is_jalr  = (opc_q == OP_JALR);
    is_lui   = (opc_q == OP_LUI);
    alu_op_dec = 2'd0;
    if (opc_q == OP_R)      alu_op_dec = 2'd2;
    else if (opc_q == OP_I) alu_op_dec = 2'd3;
    else if (is_br)         alu_op_dec = 2'd1;
    alu_src_dec = (opc_q == OP_I) || is_load || is_store || is_jalr || (opc_q == OP_AUIPC);
    stall_hit   = (wait_cnt_q == CNT_W'(STALL_LIMIT - 1));
  end

  // Next-state, wait counter and output strobes; reset forces all outputs quiet.
  always_comb begin
    state_d       = state_q;
    opc_d         = opc_q;
    wait_cnt_d    = '0;
    CTL_IrWrite   = 1'b0;
    CTL_PcWrite   = 1'b0;
    CTL_PcSel     = 2'd0;
    CTL_RegWrite  = 1'b0;
    CTL_AluOp     = 2'd0;
    CTL_AluSrc    = 1'b0;
    CTL_MemRead   = 1'b0;
    CTL_MemWrite  = 1'b0;
    CTL_MemToReg  = 3'd0;
    CTL_Fault     = 1'b0;
    instr_retired = 1'b0;
    case (state_q)
      S_FETCH: begin
        CTL_MemRead = 1'b1;
        if (mem_ready) begin
          CTL_IrWrite = 1'b1;
          state_d     = S_DECODE;
        end else if (stall_hit) begin
          state_d = S_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        opc_d   = inst_opc;
        state_d = opc_in_valid ? S_EXEC : S_FAULT;
      end
      S_EXEC: begin
        CTL_AluOp  = alu_op_dec;
        CTL_AluSrc = alu_src_dec;
        if (is_br) begin
          CTL_PcWrite   = 1'b1;
          CTL_PcSel     = take_branch ? 2'd1 : 2'd0;
          instr_retired = 1'b1;
          state_d       = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        CTL_AluOp    = alu_op_dec;
        CTL_AluSrc   = alu_src_dec;
        CTL_MemWrite = is_store;
        CTL_MemRead  = !is_store;
        if (mem_ready) begin
          if (is_store) begin
            CTL_PcWrite   = 1'b1;
            instr_retired = 1'b1;
            state_d       = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (stall_hit) begin
          state_d = S_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_WB: begin
        CTL_AluOp     = alu_op_dec;
        CTL_AluSrc    = alu_src_dec;
        CTL_RegWrite  = 1'b1;
        CTL_PcWrite   = 1'b1;
        instr_retired = 1'b1;
        CTL_PcSel     = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        if (is_load)               CTL_MemToReg = 3'd1;
        else if (is_jal || is_jalr) CTL_MemToReg = 3'd2;
        else if (is_lui)           CTL_MemToReg = 3'd3;
        state_d = S_FETCH;
      end
      S_FAULT: begin
        CTL_Fault = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
    if (rst) begin
      CTL_IrWrite   = 1'b0;
      CTL_PcWrite   = 1'b0;
      CTL_PcSel     = 2'd0;
      CTL_RegWrite  = 1'b0;
      CTL_AluOp     = 2'd0;
      CTL_AluSrc    = 1'b0;
      CTL_MemRead   = 1'b0;
      CTL_MemWrite  = 1'b0;
      CTL_MemToReg  = 3'd0;
      CTL_Fault     = 1'b0;
      instr_retired = 1'b0;
    end
  end

  // State, latched opcode and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      opc_q      <= 7'd0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      opc_q      <= opc_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule
